// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, ALU operation
// classes, state encoding and the control output bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } ctrl_state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       branch;
    logic       pc_write;
  } ctrl_out_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output table: maps the current control state to every datapath
// enable and select. Unused encodings decode to all zeros.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  ctrl_state_t state,
  output ctrl_out_t   ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = 2'b00;
        ctrl.pc_write  = 1'b1;
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = 2'b01;
        ctrl.branch    = 1'b1;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// opcode-driven next-state logic and the PC enable gate.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic [3:0] State
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  ctrl_out_t   ctrl_raw;
  ctrl_out_t   ctrl;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      // Op is held in the IR here, so only lw and sw can reach this state.
      MEMADR:  state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  ctrl_output_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl_raw)
  );

  // Reset masks every output so an aborted instruction cannot write anything.
  assign ctrl      = reset ? '0 : ctrl_raw;
  assign IorD      = ctrl.iord;
  assign MemWrite  = ctrl.mem_write;
  assign IRWrite   = ctrl.ir_write;
  assign RegDst    = ctrl.reg_dst;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign RegWrite  = ctrl.reg_write;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign PCSrc     = ctrl.pc_src;
  assign PCEn      = ctrl.pc_write | (ctrl.branch & Zero);
  assign IllegalOp = !reset && (state_q == DECODE) && !is_legal_op(Op);
  assign State     = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a driver pushes the expected
// per-cycle output vector, a negedge monitor pops and compares.
module tb_multicycle_controller;

  localparam int W = 19;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, IllegalOp;
  logic [3:0] State;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] act;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .IllegalOp(IllegalOp), .State(State)
  );

  assign act = {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp};

  // Field order: state, iord, mw, irw, rdst, m2r, rw, asa, asb, aop, pcs, pcen, ill
  function automatic logic [W-1:0] mk(input logic [3:0] st, input logic iord,
      input logic mw, input logic irw, input logic rdst, input logic m2r,
      input logic rw, input logic asa, input logic [1:0] asb,
      input logic [1:0] aop, input logic [1:0] pcs, input logic pcen,
      input logic ill);
    return {st, iord, mw, irw, rdst, m2r, rw, asa, asb, aop, pcs, pcen, ill};
  endfunction

  function automatic logic [W-1:0] e_fetch();
    return mk(4'd0, 0,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 1, 0);
  endfunction
  function automatic logic [W-1:0] e_decode(input logic ill);
    return mk(4'd1, 0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0, ill);
  endfunction

  logic [W-1:0] E_ZERO, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR, E_EXEC, E_ALUWB;
  logic [W-1:0] E_ADDIEX, E_ADDIWB, E_JUMP;

  initial begin
    E_ZERO   = '0;
    E_MEMADR = mk(4'd2,  0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0, 0);
    E_MEMRD  = mk(4'd3,  1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 0);
    E_MEMWB  = mk(4'd4,  0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0, 0);
    E_MEMWR  = mk(4'd5,  1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 0);
    E_EXEC   = mk(4'd6,  0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0, 0);
    E_ALUWB  = mk(4'd7,  0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0, 0);
    E_ADDIEX = mk(4'd9,  0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0, 0);
    E_ADDIWB = mk(4'd10, 0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0, 0);
    E_JUMP   = mk(4'd11, 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1, 0);
  end

  function automatic logic [W-1:0] e_branch(input logic z);
    return mk(4'd8, 0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, z, 0);
  endfunction

  // One clock cycle: drive inputs just after the edge and queue the
  // response expected for that cycle.
  task automatic step(input logic r, input logic [5:0] op, input logic z,
                      input logic [W-1:0] e, input string tag);
    @(posedge clk);
    #1;
    reset = r;
    Op    = op;
    Zero  = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %05h expected %05h (State got %0d)", t, act, e, State);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 6'b100011, 1'b0, '0, "reset_hold");

    step(0, 6'b100011, 0, e_fetch(),    "lw_fetch");
    step(0, 6'b100011, 0, e_decode(0),  "lw_decode");
    step(0, 6'b100011, 0, E_MEMADR,     "lw_memadr");
    step(0, 6'b100011, 0, E_MEMRD,      "lw_memrd");
    step(0, 6'b100011, 0, E_MEMWB,      "lw_memwb");

    step(0, 6'b101011, 0, e_fetch(),    "sw_fetch");
    step(0, 6'b101011, 0, e_decode(0),  "sw_decode");
    step(0, 6'b101011, 0, E_MEMADR,     "sw_memadr");
    step(0, 6'b101011, 0, E_MEMWR,      "sw_memwr");

    step(0, 6'b000000, 0, e_fetch(),    "r_fetch");
    step(0, 6'b000000, 0, e_decode(0),  "r_decode");
    step(0, 6'b000000, 1, E_EXEC,       "r_execute");
    step(0, 6'b000000, 0, E_ALUWB,      "r_aluwb");

    step(0, 6'b001000, 0, e_fetch(),    "addi_fetch");
    step(0, 6'b001000, 0, e_decode(0),  "addi_decode");
    step(0, 6'b001000, 0, E_ADDIEX,     "addi_ex");
    step(0, 6'b001000, 0, E_ADDIWB,     "addi_wb");

    step(0, 6'b000100, 1, e_fetch(),    "beq1_fetch");
    step(0, 6'b000100, 1, e_decode(0),  "beq1_decode");
    step(0, 6'b000100, 1, e_branch(1),  "beq_taken");
    step(0, 6'b000100, 0, e_fetch(),    "beq0_fetch");
    step(0, 6'b000100, 0, e_decode(0),  "beq0_decode");
    step(0, 6'b000100, 0, e_branch(0),  "beq_not_taken");

    step(0, 6'b000010, 0, e_fetch(),    "j_fetch");
    step(0, 6'b000010, 1, e_decode(0),  "j_decode");
    step(0, 6'b000010, 0, E_JUMP,       "j_jump");

    step(0, 6'b111111, 0, e_fetch(),    "ill_fetch");
    step(0, 6'b111111, 0, e_decode(1),  "ill_decode");

    step(0, 6'b101011, 0, e_fetch(),    "swrst_fetch");
    step(0, 6'b101011, 0, e_decode(0),  "swrst_decode");
    step(1, 6'b101011, 0, E_ZERO,       "swrst_reset_in_memadr");
    step(0, 6'b101011, 0, e_fetch(),    "swrst_fetch_after");
    step(0, 6'b101011, 0, e_decode(0),  "swrst_decode_after");
    step(0, 6'b101011, 0, E_MEMADR,     "swrst_memadr_after");
    step(0, 6'b101011, 0, E_MEMWR,      "swrst_memwr_after");
    step(0, 6'b000000, 0, e_fetch(),    "final_fetch");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
